// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// SPI responder for CPOL=0 masters (CPHA selectable per frame through `mode`).
// ssck, scs_n and smosi are asynchronous to clk. They are resynchronised and
// all shifting happens in the clk domain, driven by edges detected on the
// synchronised serial clock. A one-byte holding register separates the local
// writer from the bit timing. Received bytes are announced with a one-clock
// strobe.
//
// Ports
//   clk       system clock
//   rst       synchronous, active-high reset
//   mode      0: CPHA=0, 1: CPHA=1 (captured only while chip select is high)
//   ssck      serial clock from the master (async)
//   scs_n     chip select, active low (async)
//   smosi     master-out data (async)
//   smiso     slave-out data (registered, idles high)
//   tx_din    byte to transmit next
//   tx_wr     write strobe for tx_din
//   tx_empty  holding register is free
//   rx_dout   last complete received byte
//   rx_stb    one-clock pulse, rx_dout has just been updated
//   active    synchronised chip select is asserted
//
// Handshake: tx_wr is a single-cycle request. It is accepted only when
// tx_empty is 1 in that same cycle; a write while tx_empty is 0 is dropped.
// rx_stb is a single-cycle notification with no back-pressure: rx_dout holds
// the byte until the next strobe.
//
// SYNC_STAGES must be 2 or 3. Each ssck half-period must last at least
// SYNC_STAGES+2 clk cycles; an ssck edge takes effect SYNC_STAGES+1 clk
// cycles after it occurs on the pin.
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       ssck,
    input  logic       scs_n,
    input  logic       smosi,
    output logic       smiso,
    input  logic [7:0] tx_din,
    input  logic       tx_wr,
    output logic       tx_empty,
    output logic [7:0] rx_dout,
    output logic       rx_stb,
    output logic       active
);

    // -------------------------------------------------------------------------
    // Frame state. WAIT_HIGH is entered on reset so that a chip select that is
    // already low when reset is released never opens a frame; the master has
    // to deassert and reassert it first.
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_WAIT_HIGH = 2'd0,
        ST_IDLE      = 2'd1,
        ST_FRAME     = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // -------------------------------------------------------------------------
    // Synchronisers. Index 0 is the flop nearest the pin.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   s_sck_d;

    logic s_sck;
    logic s_cs_n;
    logic s_mosi;

    assign s_sck  = sck_sync[SYNC_STAGES-1];
    assign s_cs_n = cs_sync[SYNC_STAGES-1];
    assign s_mosi = mosi_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            s_sck_d   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], ssck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], scs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], smosi};
            s_sck_d   <= s_sck;
        end
    end

    logic sck_rise;
    logic sck_fall;

    assign sck_rise = s_sck & ~s_sck_d;
    assign sck_fall = ~s_sck & s_sck_d;

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    logic       mode_q;     // CPHA for the current / next frame
    logic [2:0] cnt;        // bits sampled so far in the current byte
    logic [7:0] rx_shift;   // receive shifter, newest bit in [0]
    logic [7:0] tx_shift;   // transmit shifter, next bit to send in [7]
    logic [7:0] hold;       // holding register contents

    // -------------------------------------------------------------------------
    // Event decode
    // -------------------------------------------------------------------------
    logic       frame_start;
    logic       frame_end;
    logic       in_frame;
    logic       sample_evt;
    logic       shift_evt;
    logic       load_evt;
    logic [7:0] load_byte;

    always_comb begin
        frame_start = (state == ST_IDLE) && !s_cs_n;
        frame_end   = (state == ST_FRAME) && s_cs_n;
        // Frame end takes priority: an edge seen in the same cycle as the
        // chip-select release is ignored.
        in_frame    = (state == ST_FRAME) && !s_cs_n;

        sample_evt  = in_frame && (mode_q ? sck_fall : sck_rise);
        shift_evt   = in_frame && (mode_q ? sck_rise : sck_fall);

        // In CPHA=0 the first bit has to be on smiso before the first rising
        // edge, so the first byte is loaded as soon as the frame opens. Every
        // other byte is loaded on the shift edge that starts it (cnt==0).
        load_evt    = (frame_start && !mode_q) || (shift_evt && (cnt == 3'd0));

        // Byte chosen at a load: pending holding data first, then a write
        // arriving in this very cycle, otherwise all-ones (underrun).
        if (!tx_empty) begin
            load_byte = hold;
        end else if (tx_wr) begin
            load_byte = tx_din;
        end else begin
            load_byte = 8'hFF;
        end
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_WAIT_HIGH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_WAIT_HIGH: if (s_cs_n)  state_next = ST_IDLE;
            ST_IDLE:      if (!s_cs_n) state_next = ST_FRAME;
            ST_FRAME:     if (s_cs_n)  state_next = ST_IDLE;
            default:                   state_next = ST_WAIT_HIGH;
        endcase
    end

    assign active = (state == ST_FRAME);

    // -------------------------------------------------------------------------
    // Shifters, counter, receive output
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= 1'b0;
            cnt      <= 3'd0;
            rx_shift <= 8'h00;
            tx_shift <= 8'hFF;
            smiso    <= 1'b1;
            rx_dout  <= 8'h00;
            rx_stb   <= 1'b0;
        end else begin
            rx_stb <= 1'b0;

            // mode is frozen while chip select is low, so the value present
            // when the frame opens governs the whole frame.
            if (s_cs_n) begin
                mode_q <= mode;
            end

            if (frame_start) begin
                cnt <= 3'd0;
            end

            if (frame_end) begin
                // A partial byte is dropped simply by clearing the counter.
                cnt   <= 3'd0;
                smiso <= 1'b1;
            end

            if (sample_evt) begin
                rx_shift <= {rx_shift[6:0], s_mosi};
                cnt      <= cnt + 3'd1;
                if (cnt == 3'd7) begin
                    rx_dout <= {rx_shift[6:0], s_mosi};
                    rx_stb  <= 1'b1;
                end
            end

            if (load_evt) begin
                // Bit 7 goes out now; bit 6 sits at [7] for the next shift.
                smiso    <= load_byte[7];
                tx_shift <= {load_byte[6:0], 1'b1};
            end else if (shift_evt) begin
                smiso    <= tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b1};
            end
        end
    end

    // -------------------------------------------------------------------------
    // Holding register. A write that coincides with a load while the register
    // is empty goes straight into the shifter (see load_byte), so tx_empty
    // stays set in that case.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hold     <= 8'h00;
            tx_empty <= 1'b1;
        end else begin
            if (load_evt) begin
                tx_empty <= 1'b1;
            end else if (tx_wr && tx_empty) begin
                hold     <= tx_din;
                tx_empty <= 1'b0;
            end
        end
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (CPOL=0) that accepts bytes from an external master and returns bytes supplied by the local side.
- ssck, scs_n and smosi are asynchronous to clk. They are resynchronised, and all shifting is done in the clk domain by edge detection on the synchronised ssck.
- A one-byte TX holding register decouples the local writer from the bit timing.
- Received bytes are delivered with a 1-clock strobe, matching the strobe style of the existing SPI master.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on ssck/scs_n/smosi (legal range 2..3).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = CPHA=0, CPOL=0; 1 = CPHA=1, CPOL=0; sampled only while scs_n (synchronised) is high
- ssck  in  1  serial clock from master (async)
- scs_n  in  1  chip select, active low (async)
- smosi  in  1  master-out data (async)
- smiso  out  1  slave-out data, registered
- tx_din  in  8  byte to transmit next
- tx_wr  in  1  write strobe for tx_din
- tx_empty  out  1  holding register free
- rx_dout  out  8  last complete received byte
- rx_stb  out  1  1-clock pulse, rx_dout updated
- active  out  1  synchronised chip select asserted

Behaviour:
- Reset values: smiso=1, tx_empty=1, rx_dout=8'h00, rx_stb=0, active=0. Bit counter, shifter and synchroniser history are cleared.
- Reset asserted mid-frame aborts the frame with no rx_stb. After reset, nothing is shifted until scs_n is seen high and then low again.
- Synchronisers: SYNC_STAGES flip-flops on each async input, plus one history flop on ssck.
  - rise = s_sck & !s_sck_d; fall = !s_sck & s_sck_d.
  - Edge-to-action latency is SYNC_STAGES+1 clk.
  - Legal master timing: each ssck half-period ≥ SYNC_STAGES+2 clk.
- Edge roles:
  - mode 0: sample edge = rise, shift edge = fall.
  - mode 1: sample edge = fall, shift edge = rise.
  - mode is latched into a frame register on scs_n assertion.
- Idle (active=0): bit counter cnt[2:0]=0, smiso=1, edges ignored.
- Frame start (s_cs_n falls): active=1, cnt=0.
  - In mode 0 a load event occurs in the same cycle, so bit 7 is on smiso before the first rise.
- Sample edge:
  - shift[0] ← s_mosi, cnt ← cnt+1 (wraps 7→0).
  - If cnt was 7: rx_dout ← {shift[6:0], s_mosi} and rx_stb=1 in the next cycle.
- Shift edge:
  - If cnt==0: load event.
  - Otherwise smiso ← shift[7] and shift ← shift<<1.
- Load event:
  - If tx_empty=0: shifter ← holding, tx_empty ← 1.
  - If tx_empty=1: shifter ← 8'hFF (underrun, no flag).
  - smiso ← bit 7 of the loaded byte. The shifter is then positioned so bit 6 goes out on the next shift.
- Holding register:
  - tx_wr with tx_empty=1 captures tx_din and sets tx_empty=0.
  - tx_wr with tx_empty=0 is ignored (data dropped).
  - tx_wr in the same cycle as a load event with tx_empty=1: tx_din bypasses straight into the shifter and tx_empty stays 1.
- Frame end (s_cs_n rises):
  - active=0, smiso=1, cnt=0.
  - A partial byte (cnt≠0) is discarded with no rx_stb.
  - An unsent holding byte is kept for the next frame.
- Simultaneous frame end and sample edge in one cycle: frame end wins and the sample is discarded.
- rx_stb is never asserted for more than 1 cycle. Back-to-back bytes give strobes ≥ 16·(SYNC_STAGES+2) clk apart.

Test Plan:
- Mode 0, holding preloaded with 8'hA5, master sends 8'h3C in one 8-bit frame (half-period 6 clk):
  - master sees 8'hA5 on smiso.
  - rx_dout=8'h3C with a single rx_stb.
  - tx_empty goes 1 after frame start.
- Mode 1, two-byte frame, second byte written via tx_wr during the first byte; master sends 8'h01, 8'h80:
  - smiso bytes are the first and second written values.
  - two rx_stb with rx_dout 8'h01 then 8'h80.
- Underrun: no tx_wr, 8-bit frame:
  - master reads 8'hFF.
  - rx still captured.
- Abort: scs_n released after 5 ssck cycles:
  - no rx_stb, smiso=1, active=0.
  - next full frame receives correctly from bit 7.
- tx_wr while tx_empty=0 (values 8'h11 then 8'h22):
  - 8'h11 transmitted, 8'h22 dropped.
- Bypass: tx_wr 8'h5A in the exact cycle of the mode-0 load event with tx_empty=1:
  - 8'h5A is shifted out and tx_empty remains 1.
- Reset mid-frame after 3 bits:
  - all outputs return to reset values, with no rx_stb for that frame.
